// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: ID-side and EX-side handshake/data bundle for the ID/EX pipeline register
interface id_ex_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3,
  parameter int CNT_W      = 16
);
  logic                  i_flush;
  logic                  i_valid;
  logic                  o_id_ready;
  logic [ALUSEL_W-1:0]   i_alusel;
  logic [ALUOP_W-1:0]    i_aluop;
  logic [DATA_W-1:0]     i_reg1_data;
  logic [DATA_W-1:0]     i_reg2_data;
  logic                  i_wreg;
  logic [REG_ADDR_W-1:0] i_wreg_addr;
  logic                  o_valid;
  logic                  i_ex_ready;
  logic [ALUSEL_W-1:0]   o_alusel;
  logic [ALUOP_W-1:0]    o_aluop;
  logic [DATA_W-1:0]     o_reg1_data;
  logic [DATA_W-1:0]     o_reg2_data;
  logic                  o_wreg;
  logic [REG_ADDR_W-1:0] o_wreg_addr;
  logic [CNT_W-1:0]      o_stall_cnt;
  modport master (
    output i_flush, i_valid, i_alusel, i_aluop, i_reg1_data, i_reg2_data, i_wreg, i_wreg_addr, i_ex_ready,
    input  o_id_ready, o_valid, o_alusel, o_aluop, o_reg1_data, o_reg2_data, o_wreg, o_wreg_addr, o_stall_cnt
  );
  modport slave (
    input  i_flush, i_valid, i_alusel, i_aluop, i_reg1_data, i_reg2_data, i_wreg, i_wreg_addr, i_ex_ready,
    output o_id_ready, o_valid, o_alusel, o_aluop, o_reg1_data, o_reg2_data, o_wreg, o_wreg_addr, o_stall_cnt
  );
endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with valid/ready handshake, flush and stall counter; ID_EX_SKID_EN adds a registered-ready skid entry
module id_ex_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int ALUSEL_W   = 3,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_pipe_if.slave bus
);
  localparam int W = ALUSEL_W + ALUOP_W + 2 * DATA_W + 1 + REG_ADDR_W;
  logic [W-1:0]     in_w, main_q, main_d;
  logic             main_v_q, main_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, consume, w_st;
  assign in_w    = {bus.i_alusel, bus.i_aluop, bus.i_reg1_data, bus.i_reg2_data, bus.i_wreg, bus.i_wreg_addr};
  assign consume = main_v_q & bus.i_ex_ready;
  assign {bus.o_alusel, bus.o_aluop, bus.o_reg1_data, bus.o_reg2_data, w_st, bus.o_wreg_addr} = main_q;
  assign bus.o_valid     = main_v_q;
  assign bus.o_wreg      = w_st & main_v_q;
  assign bus.o_stall_cnt = cnt_q;
`ifdef ID_EX_SKID_EN
  logic [W-1:0] skid_q, skid_d;
  logic         skid_v_q, skid_v_d;
  assign bus.o_id_ready = ~skid_v_q;
  assign accept         = bus.i_valid & ~skid_v_q;
  // Main refills from skid before the input to keep order; skid catches a word only while main is stuck
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (bus.i_flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || consume) begin
      main_v_d = skid_v_q | accept;
      main_d   = skid_v_q ? skid_q : accept ? in_w : main_q;
      skid_v_d = 1'b0;
    end else if (accept) begin
      skid_d   = in_w;
      skid_v_d = 1'b1;
    end
  end
  // Skid entry registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
`else
  assign bus.o_id_ready = ~main_v_q | bus.i_ex_ready;
  assign accept         = bus.i_valid & bus.o_id_ready;
  // Single entry loads on accept, empties on consume or flush
  always_comb begin
    main_d   = accept ? in_w : main_q;
    main_v_d = ~bus.i_flush & (accept | (main_v_q & ~consume));
  end
`endif
  // Back-pressure counter saturates and survives flush
  always_comb cnt_d = (main_v_q & ~bus.i_ex_ready & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  // Main entry and stall counter registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      cnt_q    <= cnt_d;
    end
endmodule
